// File: rtl/ifu_pkg.sv
// Shared fetch-unit types: sequencer states, reset PC and the canonical NOP encoding.
package ifu_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    ISSUE = 3'd3,
    EXEC  = 3'd4,
    FAULT = 3'd5
  } state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

endpackage

// File: rtl/ifu_fetch_timer.sv
// WAIT-state watchdog: counts WAIT cycles, flags expiry on the TIMEOUT_CYCLES-th one.
// Zero latency on expired_o; no backpressure, cleared whenever a new request is accepted.
module ifu_fetch_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  input  logic in_wait_i,
  output logic expired_o
);

  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (in_wait_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of completed WAIT cycles, so LAST marks the final allowed one.
  assign expired_o = in_wait_i && (cnt_q == LAST);

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Fetch sequencer: one imem read per instruction, decode handshake, PC write on commit; loop = 4 cycles + exec.
// Request and instruction are held stable until accepted; FETCH_TIMEOUT_EN adds a WAIT timeout fault.
module ifu_fetch_ctrl
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pc_i,
  output logic        pc_wen_o,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_data_i,
  input  logic        imem_resp_err_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        commit_i,
  output logic        fetch_fault_o,
  output logic [31:0] fault_pc_o
);

  state_e      state_q, state_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic        req_fire;
  logic        timeout;

  assign imem_req_valid_o = (state_q == REQ) && (pc_i[1:0] == 2'b00);
  assign imem_req_addr_o  = (state_q == REQ) ? pc_i : 32'h0;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign inst_valid_o     = (state_q == ISSUE);
  assign pc_wen_o         = (state_q == EXEC) && commit_i;
  assign fetch_fault_o    = (state_q == FAULT);
  assign inst_o           = inst_q;
  assign inst_pc_o        = inst_pc_q;
  assign fault_pc_o       = fault_pc_q;

`ifdef FETCH_TIMEOUT_EN
  ifu_fetch_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (req_fire),
    .in_wait_i (state_q == WAIT),
    .expired_o (timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    fault_pc_d = fault_pc_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (pc_i[1:0] != 2'b00) begin
          state_d    = FAULT;
          fault_pc_d = pc_i;
        end else if (req_fire) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A response in the timeout cycle takes priority over the fault.
        if (imem_resp_valid_i && !imem_resp_err_i) begin
          state_d   = ISSUE;
          inst_d    = imem_resp_data_i;
          inst_pc_d = pc_i;
        end else if (imem_resp_valid_i || timeout) begin
          state_d    = FAULT;
          fault_pc_d = pc_i;
        end
      end
      ISSUE: if (inst_ready_i) state_d = EXEC;
      EXEC:  if (commit_i) state_d = REQ;
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      inst_q     <= 32'h0;
      inst_pc_q  <= RESET_PC;
      fault_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      fault_pc_q <= fault_pc_d;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Bench for ifu_fetch_ctrl: scripted cycle-by-cycle stimulus with an expected-instruction scoreboard.
module tb_ifu_fetch_ctrl;
  import ifu_pkg::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        pc_wen;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        commit;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  int   checks = 0;
  int   failures = 0;
  int   acc_cnt = 0;
  int   vld_cnt = 0;
  int   wen_cnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ifu_fetch_ctrl #(
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .pc_i             (pc),
    .pc_wen_o         (pc_wen),
    .imem_req_valid_o (imem_req_valid),
    .imem_req_ready_i (imem_req_ready),
    .imem_req_addr_o  (imem_req_addr),
    .imem_resp_valid_i(imem_resp_valid),
    .imem_resp_data_i (imem_resp_data),
    .imem_resp_err_i  (imem_resp_err),
    .inst_valid_o     (inst_valid),
    .inst_ready_i     (inst_ready),
    .inst_o           (inst),
    .inst_pc_o        (inst_pc),
    .commit_i         (commit),
    .fetch_fault_o    (fetch_fault),
    .fault_pc_o       (fault_pc)
  );

  always @(negedge clk) begin
    if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) acc_cnt++;
    if (imem_req_valid === 1'b1) vld_cnt++;
    if (pc_wen === 1'b1) wen_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drv_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    pc = RST_PC;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    imem_resp_err = 1'b0;
    inst_ready = 1'b0;
    commit = 1'b0;
    drv_edge();
    drv_edge();
    reset = 1'b0;
  endtask

  // Drives one complete fetch starting in a REQ cycle; returns what decode saw and a stability error count.
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] w, input int rs, input int ds, input int ew,
                           output logic [31:0] gi, output logic [31:0] gp, output logic giv, output int bad,
                           output logic gw);
    bad = 0;
    pc = a;
    imem_req_ready = 1'b0;
    for (int i = 0; i < rs; i++) begin
      @(negedge clk);
      if (imem_req_valid !== 1'b1 || imem_req_addr !== a) bad++;
      drv_edge();
    end
    imem_req_ready = 1'b1;
    @(negedge clk);
    if (imem_req_valid !== 1'b1 || imem_req_addr !== a) bad++;
    drv_edge();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = w;
    imem_resp_err = 1'b0;
    @(negedge clk);
    if (imem_req_valid !== 1'b0) bad++;
    drv_edge();
    imem_resp_valid = 1'b0;
    imem_resp_data = 32'h0;
    inst_ready = 1'b0;
    for (int i = 0; i < ds; i++) begin
      @(negedge clk);
      if (inst_valid !== 1'b1 || inst !== w || inst_pc !== a) bad++;
      drv_edge();
    end
    inst_ready = 1'b1;
    @(negedge clk);
    gi = inst;
    gp = inst_pc;
    giv = inst_valid;
    drv_edge();
    inst_ready = 1'b0;
    commit = 1'b0;
    for (int i = 0; i < ew; i++) begin
      @(negedge clk);
      if (pc_wen !== 1'b0) bad++;
      drv_edge();
    end
    commit = 1'b1;
    @(negedge clk);
    gw = pc_wen;
    drv_edge();
    commit = 1'b0;
    pc = a + 32'd4;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({pc_wen, imem_req_valid, inst_valid, fetch_fault} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {pc_wen, imem_req_valid, inst_valid, fetch_fault});
    end
    checks++;
    if ({imem_req_addr, inst} !== 64'h0) begin
      failures++;
      $display("FAIL reset_addr_inst got=%h_%h exp=0", imem_req_addr, inst);
    end
    checks++;
    if (inst_pc !== RST_PC || fault_pc !== RST_PC) begin
      failures++;
      $display("FAIL reset_pcs got=%h/%h exp=%h", inst_pc, fault_pc, RST_PC);
    end
    drv_edge();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_no_req got=%b exp=0", imem_req_valid);
    end
    drv_edge();
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      failures++;
      $display("FAIL first_req got=%b/%h exp=1/%h", imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] gi, gp;
    logic giv, gw;
    int bad, a0, w0;
    exp_t e;
    do_reset();
    drv_edge();
    a0 = acc_cnt;
    w0 = wen_cnt;
    exp_q.push_back('{inst: 32'h0010_0093, pc: RST_PC});
    fetch_one(RST_PC, 32'h0010_0093, 0, 0, 1, gi, gp, giv, bad, gw);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL zw_scoreboard got=empty exp=entry");
    end else begin
      e = exp_q.pop_front();
      if ({giv, gi, gp} !== {1'b1, e.inst, e.pc}) begin
        failures++;
        $display("FAIL zw_inst got=%b/%h/%h exp=1/%h/%h", giv, gi, gp, e.inst, e.pc);
      end
    end
    checks++;
    if (gw !== 1'b1 || bad != 0) begin
      failures++;
      $display("FAIL zw_pc_wen got=%b bad=%0d exp=1 bad=0", gw, bad);
    end
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC + 32'd4 || pc_wen !== 1'b0) begin
      failures++;
      $display("FAIL zw_next_req got=%b/%h wen=%b exp=1/%h wen=0", imem_req_valid, imem_req_addr, pc_wen, RST_PC + 32'd4);
    end
    checks++;
    if (acc_cnt - a0 != 1 || wen_cnt - w0 != 1) begin
      failures++;
      $display("FAIL zw_counts got acc=%0d wen=%0d exp=1/1", acc_cnt - a0, wen_cnt - w0);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] gi, gp;
    logic giv, gw;
    int bad, a0, w0;
    exp_t e;
    a0 = acc_cnt;
    w0 = wen_cnt;
    exp_q.push_back('{inst: NOP_INSN, pc: RST_PC + 32'd4});
    fetch_one(RST_PC + 32'd4, NOP_INSN, 3, 2, 0, gi, gp, giv, bad, gw);
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_stable got=%0d unstable cycles exp=0", bad);
    end
    checks++;
    e = exp_q.pop_front();
    if ({giv, gi, gp} !== {1'b1, e.inst, e.pc}) begin
      failures++;
      $display("FAIL bp_inst got=%b/%h/%h exp=1/%h/%h", giv, gi, gp, e.inst, e.pc);
    end
    checks++;
    if (acc_cnt - a0 != 1 || wen_cnt - w0 != 1 || gw !== 1'b1) begin
      failures++;
      $display("FAIL bp_single got acc=%0d wen=%0d exp=1/1", acc_cnt - a0, wen_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] gi, gp, w, a;
    logic giv, gw;
    int bad, a0;
    exp_t e;
    a0 = acc_cnt;
    a = pc;
    for (int i = 0; i < 4; i++) begin
      w = $urandom;
      exp_q.push_back('{inst: w, pc: a});
      fetch_one(a, w, 0, 0, 0, gi, gp, giv, bad, gw);
      e = exp_q.pop_front();
      checks++;
      if ({giv, gi, gp} !== {1'b1, e.inst, e.pc} || gw !== 1'b1 || bad != 0) begin
        failures++;
        $display("FAIL b2b_%0d got=%b/%h/%h wen=%b bad=%0d exp=1/%h/%h wen=1 bad=0", i, giv, gi, gp, gw, bad, e.inst, e.pc);
      end
      a = a + 32'd4;
    end
    checks++;
    if (acc_cnt - a0 != 4) begin
      failures++;
      $display("FAIL b2b_requests got=%0d exp=4", acc_cnt - a0);
    end
  endtask

  task automatic test_stray();
    int w0;
    exp_t e;
    do_reset();
    w0 = wen_cnt;
    pc = 32'h8000_0020;
    commit = 1'b1;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hDEAD_BEEF;
    drv_edge();
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || pc_wen !== 1'b0) begin
      failures++;
      $display("FAIL stray_req_hold got=%b wen=%b exp=1 wen=0", imem_req_valid, pc_wen);
    end
    drv_edge();
    imem_req_ready = 1'b1;
    drv_edge();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    drv_edge();
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'h0020_0113;
    exp_q.push_back('{inst: 32'h0020_0113, pc: 32'h8000_0020});
    commit = 1'b0;
    drv_edge();
    imem_resp_valid = 1'b0;
    commit = 1'b1;
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({inst_valid, inst, inst_pc} !== {1'b1, e.inst, e.pc}) begin
      failures++;
      $display("FAIL stray_capture got=%b/%h/%h exp=1/%h/%h", inst_valid, inst, inst_pc, e.inst, e.pc);
    end
    drv_edge();
    @(negedge clk);
    checks++;
    if (wen_cnt - w0 != 0 || inst_valid !== 1'b1) begin
      failures++;
      $display("FAIL stray_commit got wen=%0d ivld=%b exp=0/1", wen_cnt - w0, inst_valid);
    end
    commit = 1'b0;
    inst_ready = 1'b1;
    drv_edge();
    inst_ready = 1'b0;
    commit = 1'b1;
    drv_edge();
    commit = 1'b0;
    pc = 32'h8000_0024;
    imem_req_ready = 1'b1;
    drv_edge();
    imem_req_ready = 1'b0;
    reset = 1'b1;
    drv_edge();
    reset = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data = 32'hBAD0_0BAD;
    @(negedge clk);
    checks++;
    if ({imem_req_valid, inst_valid, pc_wen} !== 3'b000 || inst !== 32'h0 || inst_pc !== RST_PC) begin
      failures++;
      $display("FAIL stray_mid_reset got=%b/%h/%h exp=000/0/%h", {imem_req_valid, inst_valid, pc_wen}, inst, inst_pc, RST_PC);
    end
    drv_edge();
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0024) begin
      failures++;
      $display("FAIL stray_restart got=%b/%h exp=1/80000024", imem_req_valid, imem_req_addr);
    end
    drv_edge();
    imem_resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b0 || inst !== 32'h0 || wen_cnt - w0 != 1) begin
      failures++;
      $display("FAIL stray_late_resp got=%b/%h wen=%0d exp=0/0 wen=1", inst_valid, inst, wen_cnt - w0);
    end
  endtask

  task automatic test_bus_error();
    int v0, w0;
    do_reset();
    pc = 32'h8000_0010;
    imem_req_ready = 1'b1;
    drv_edge();
    drv_edge();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_err = 1'b1;
    imem_resp_data = 32'h1234_5678;
    drv_edge();
    imem_resp_valid = 1'b0;
    imem_resp_err = 1'b0;
    @(negedge clk);
    checks++;
    if (fetch_fault !== 1'b1 || fault_pc !== 32'h8000_0010 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL buserr_fault got=%b/%h ivld=%b exp=1/80000010 ivld=0", fetch_fault, fault_pc, inst_valid);
    end
    v0 = vld_cnt;
    w0 = wen_cnt;
    imem_req_ready = 1'b1;
    commit = 1'b1;
    inst_ready = 1'b1;
    pc = 32'h8000_0014;
    for (int i = 0; i < 5; i++) drv_edge();
    @(negedge clk);
    checks++;
    if (vld_cnt - v0 != 0 || wen_cnt - w0 != 0 || fetch_fault !== 1'b1) begin
      failures++;
      $display("FAIL buserr_sticky got vld=%0d wen=%0d fault=%b exp=0/0/1", vld_cnt - v0, wen_cnt - w0, fetch_fault);
    end
  endtask

  task automatic test_misaligned();
    int a0;
    do_reset();
    a0 = acc_cnt;
    pc = 32'h8000_0002;
    imem_req_ready = 1'b1;
    drv_edge();
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL misal_no_req got=%b exp=0", imem_req_valid);
    end
    drv_edge();
    @(negedge clk);
    checks++;
    if (fetch_fault !== 1'b1 || fault_pc !== 32'h8000_0002 || acc_cnt - a0 != 0) begin
      failures++;
      $display("FAIL misal_fault got=%b/%h acc=%0d exp=1/80000002 acc=0", fetch_fault, fault_pc, acc_cnt - a0);
    end
  endtask

  task automatic test_wait_limit();
    int n_wait;
    do_reset();
    pc = 32'h8000_0040;
    imem_req_ready = 1'b1;
    drv_edge();
    drv_edge();
    imem_req_ready = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    n_wait = 4;
`else
    n_wait = 300;
`endif
    for (int i = 0; i < n_wait; i++) drv_edge();
    @(negedge clk);
    checks++;
`ifdef FETCH_TIMEOUT_EN
    if (fetch_fault !== 1'b1 || fault_pc !== 32'h8000_0040) begin
      failures++;
      $display("FAIL timeout_fault got=%b/%h exp=1/80000040", fetch_fault, fault_pc);
    end
    do_reset();
    pc = 32'h8000_0044;
    imem_req_ready = 1'b1;
    drv_edge();
    drv_edge();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) drv_edge();
`else
    if (fetch_fault !== 1'b0 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL long_wait_no_fault got=%b/%b exp=0/0", fetch_fault, inst_valid);
    end
    pc = 32'h8000_0044;
`endif
    imem_resp_valid = 1'b1;
    imem_resp_data = NOP_INSN;
    drv_edge();
    imem_resp_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || fetch_fault !== 1'b0 || inst !== NOP_INSN || inst_pc !== 32'h8000_0044) begin
      failures++;
      $display("FAIL late_resp_issue got=%b/%b/%h/%h exp=1/0/%h/80000044", inst_valid, fetch_fault, inst, inst_pc, NOP_INSN);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_back_to_back();
    test_stray();
    test_bus_error();
    test_misaligned();
    test_wait_limit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_ctrl.md
# ifu_fetch_ctrl

Multi-cycle fetch sequencer for the instruction fetch unit. It takes the current PC from the PC register, issues one instruction-memory read over a valid/ready request channel, and captures the response. It then presents the instruction to decode with a valid/ready handshake and asserts the PC register write enable only when the executing instruction commits. It replaces the free-running PC update (write enable tied high) so fetch can tolerate variable memory latency.

## Interface
Parameters:
- RESET_PC, 32'h80000000, value reported on inst_pc and fault_pc out of reset
- TIMEOUT_CYCLES, 255, maximum WAIT cycles before a fetch fault (only with FETCH_TIMEOUT_EN)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high
- pc  in  32  current PC (PC register output)
- pc_wen  out  1  PC register write enable; one-cycle pulse per commit
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts the request
- imem_req_addr  out  32  fetch address
- imem_resp_valid  in  1  read data valid
- imem_resp_data  in  32  instruction word
- imem_resp_err  in  1  bus error qualifying imem_resp_valid
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts the instruction
- inst  out  32  captured instruction
- inst_pc  out  32  PC of inst
- commit  in  1  executing instruction finished; pc_next is valid at the PC register input
- fetch_fault  out  1  sticky fault flag
- fault_pc  out  32  PC that faulted

## Operation
- States: IDLE, REQ, WAIT, ISSUE, EXEC, FAULT.
- IDLE
  - Entered on reset.
  - Unconditionally moves to REQ the next cycle.
- REQ
  - imem_req_valid=1, imem_req_addr=pc.
  - If pc[1:0]!=0: go to FAULT with no request issued (imem_req_valid=0 that cycle). fault_pc=pc.
  - On imem_req_valid&&imem_req_ready: go to WAIT.
- WAIT
  - On imem_resp_valid with imem_resp_err=0: inst<=imem_resp_data, inst_pc<=pc, go to ISSUE.
  - On imem_resp_valid with imem_resp_err=1: go to FAULT, fault_pc<=pc.
- ISSUE
  - inst_valid=1.
  - On inst_ready: go to EXEC.
- EXEC
  - On commit: pc_wen=1 (combinational, EXEC&&commit), go to REQ.
- FAULT
  - Terminal; fetch_fault=1.
  - No requests issued, pc_wen=0, inst_valid=0.
  - Exits only on reset.
- Ignored inputs:
  - commit outside EXEC.
  - imem_resp_valid outside WAIT, including stale responses after a reset mid-fetch.
- Only one request is outstanding at any time.
- Reset mid-operation:
  - Next state is IDLE.
  - All outputs return to reset values; the outstanding request is abandoned.

## Timing
- Reset values:
  - pc_wen=0, imem_req_valid=0, imem_req_addr=0, inst_valid=0.
  - inst=0, inst_pc=RESET_PC, fetch_fault=0, fault_pc=RESET_PC.
- imem_req_valid stays high, with address stable, until imem_req_ready. It is never withdrawn except by reset.
- A response is accepted no earlier than the cycle after request acceptance.
- inst_valid stays high, with inst and inst_pc stable, until inst_ready.
- Minimum loop (zero-wait memory and decode), with commit in cycle N:
  - N+1: REQ with new pc, accepted.
  - N+2: WAIT, response.
  - N+3: ISSUE, inst_valid.
  - N+4: EXEC.
  - Fetch-to-fetch spacing is 4 cycles plus the execute time.
- First request after reset deasserts appears in the 2nd cycle, after IDLE.

## Configuration
- FETCH_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entry to WAIT and increments each cycle in WAIT.
  - When it reaches TIMEOUT_CYCLES without a response: go to FAULT, fault_pc<=pc.
  - A response arriving in the same cycle as the timeout wins; no fault.
- FETCH_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely. TIMEOUT_CYCLES is unused.

## Structure
- Shared package ifu_pkg:
  - state enum (IDLE..FAULT).
  - RESET_PC default constant.
  - NOP encoding 32'h00000013 for bench use.
- One natural sub-module, ifu_fetch_timer: the WAIT timeout counter, instantiated only under FETCH_TIMEOUT_EN.
- The FSM, capture registers and handshake logic live in ifu_fetch_ctrl.

## Test plan
- Zero-wait loop:
  - Stimulus: reset, pc=0x80000000; imem_req_ready=1; response the next cycle with 0x00100093; inst_ready=1; commit 1 cycle after EXEC.
  - Required: inst=0x00100093, inst_pc=0x80000000; pc_wen exactly one cycle; next request at the new pc.
- Backpressure:
  - Stimulus: imem_req_ready low 3 cycles, then inst_ready low 2 cycles.
  - Required: address and inst held stable, no duplicate request, single pc_wen.
- Bus error:
  - Stimulus: imem_resp_err=1 at pc=0x80000010.
  - Required: fetch_fault=1, fault_pc=0x80000010, no further imem_req_valid until reset.
- Misaligned:
  - Stimulus: pc=0x80000002 in REQ.
  - Required: no request issued, FAULT, fault_pc=0x80000002.
- Stray inputs:
  - Stimulus: commit pulses in ISSUE; imem_resp_valid in REQ; reset asserted in WAIT followed by a late response.
  - Required: all ignored, pc_wen=0, restart from IDLE.
- Timeout (FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=4):
  - Stimulus: no response.
  - Required: FAULT after 4 WAIT cycles.
  - Stimulus: response on the 4th WAIT cycle.
  - Required: ISSUE, no fault.
